fp_mult_pipe: RTL and testbench

- Parametrised, pipelined IEEE-754 binary floating-point multiplier; successor to the combinational single-precision multiplier.
- Exponent and mantissa widths are generic. Supports four rounding modes and raises IEEE exception flags.
- Has a fixed-latency pipeline with valid/ready handshake on both sides, so it sits in streaming datapaths between FIFOs.

---
 rtl/fp_mult_pipe.sv | 249 ++++++++++++++++++++++++
 tb/tb_fp_mult_pipe.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: four-stage pipelined IEEE-754 multiplier with generic field widths,
// four rounding modes, exception flags and a valid/ready handshake on both sides.
// Denormal operands are flushed to zero; tiny results flush to signed zero.
module fp_mult_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] A,
    input  logic [EXP_W+MAN_W:0] B,
    input  logic [1:0]           Ctrl,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] P,
    output logic [4:0]           Flags
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int EW2 = EXP_W + 2;
    localparam int PW  = 2 * MAN_W + 2;

    localparam logic signed [EW2-1:0] BIAS     = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW2-1:0] EXP_TOP  = EW2'((1 << EXP_W) - 1);
    localparam logic signed [EW2-1:0] EXP_INC  = EW2'(1);
    localparam logic signed [EW2-1:0] EXP_ZERO = '0;
    localparam logic [EXP_W-1:0]      EXP_ONES = '1;
    localparam logic [EXP_W-1:0]      EXP_MAXF = {{(EXP_W - 1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        KIND_NORMAL,
        KIND_ZERO,
        KIND_INF,
        KIND_NAN
    } ResultKind;

    logic adv;

    logic             signA, signB;
    logic [EXP_W-1:0] expA, expB;
    logic [MAN_W-1:0] fracA, fracB;
    logic             zeroA, zeroB, infA, infB, nanA, nanB, snanA, snanB, infTimesZero;
    ResultKind        kindNext;
    logic             invalidNext;

    logic                    s1Valid, s1Sign, s1Invalid;
    ResultKind               s1Kind;
    logic signed [EW2-1:0]   s1Exp;
    logic [MAN_W:0]          s1ManA, s1ManB;
    logic [1:0]              s1Ctrl;

    logic                    s2Valid, s2Sign, s2Invalid;
    ResultKind               s2Kind;
    logic signed [EW2-1:0]   s2Exp;
    logic [PW-1:0]           s2Prod;
    logic [1:0]              s2Ctrl;

    logic                    s3Valid, s3Sign, s3Invalid;
    ResultKind               s3Kind;
    logic signed [EW2-1:0]   s3Exp;
    logic [MAN_W-1:0]        s3Frac;
    logic                    s3Guard, s3Round, s3Sticky;
    logic [1:0]              s3Ctrl;

    logic [MAN_W-1:0]        normFrac;
    logic                    normGuard, normRound, normSticky;
    logic signed [EW2-1:0]   normExp;

    logic                    roundUp, carry, anyLost, toInf;
    logic [MAN_W-1:0]        roundFrac;
    logic signed [EW2-1:0]   roundExp;
    logic [W-1:0]            resultNext;
    logic [4:0]              flagsNext;

    // The whole pipe moves whenever the output slot is empty or being drained.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign signA = A[W-1];
    assign signB = B[W-1];
    assign expA  = A[W-2 -: EXP_W];
    assign expB  = B[W-2 -: EXP_W];
    assign fracA = A[MAN_W-1:0];
    assign fracB = B[MAN_W-1:0];

    // Classify both operands and decide which special result, if any, wins.
    always_comb begin
        zeroA        = (expA == '0);
        zeroB        = (expB == '0);
        infA         = (expA == EXP_ONES) && (fracA == '0);
        infB         = (expB == EXP_ONES) && (fracB == '0);
        nanA         = (expA == EXP_ONES) && (fracA != '0);
        nanB         = (expB == EXP_ONES) && (fracB != '0);
        snanA        = nanA && !fracA[MAN_W-1];
        snanB        = nanB && !fracB[MAN_W-1];
        infTimesZero = (infA && zeroB) || (zeroA && infB);
        invalidNext  = snanA || snanB || infTimesZero;
        kindNext     = KIND_NORMAL;
        if (nanA || nanB || infTimesZero) begin
            kindNext = KIND_NAN;
        end else if (infA || infB) begin
            kindNext = KIND_INF;
        end else if (zeroA || zeroB) begin
            kindNext = KIND_ZERO;
        end
    end

    // Stage 1 register: unpacked operands, biased exponent sum and rounding mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid   <= 1'b0;
            s1Sign    <= 1'b0;
            s1Invalid <= 1'b0;
            s1Kind    <= KIND_NORMAL;
            s1Exp     <= '0;
            s1ManA    <= '0;
            s1ManB    <= '0;
            s1Ctrl    <= '0;
        end else if (adv) begin
            s1Valid   <= in_valid;
            s1Sign    <= signA ^ signB;
            s1Invalid <= invalidNext;
            s1Kind    <= kindNext;
            s1Exp     <= $signed({2'b00, expA}) + $signed({2'b00, expB}) - BIAS;
            s1ManA    <= {1'b1, fracA};
            s1ManB    <= {1'b1, fracB};
            s1Ctrl    <= Ctrl;
        end
    end

    // Stage 2 register: full-width mantissa product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2Valid   <= 1'b0;
            s2Sign    <= 1'b0;
            s2Invalid <= 1'b0;
            s2Kind    <= KIND_NORMAL;
            s2Exp     <= '0;
            s2Prod    <= '0;
            s2Ctrl    <= '0;
        end else if (adv) begin
            s2Valid   <= s1Valid;
            s2Sign    <= s1Sign;
            s2Invalid <= s1Invalid;
            s2Kind    <= s1Kind;
            s2Exp     <= s1Exp;
            s2Prod    <= PW'(s1ManA) * PW'(s1ManB);
            s2Ctrl    <= s1Ctrl;
        end
    end

    // Normalise the product (it lies in [1,4)) and pick out guard, round and sticky.
    always_comb begin
        if (s2Prod[PW-1]) begin
            normFrac   = s2Prod[PW-2 -: MAN_W];
            normGuard  = s2Prod[MAN_W];
            normRound  = s2Prod[MAN_W-1];
            normSticky = |s2Prod[MAN_W-2:0];
            normExp    = s2Exp + EXP_INC;
        end else begin
            normFrac   = s2Prod[PW-3 -: MAN_W];
            normGuard  = s2Prod[MAN_W-1];
            normRound  = s2Prod[MAN_W-2];
            normSticky = |s2Prod[MAN_W-3:0];
            normExp    = s2Exp;
        end
    end

    // Stage 3 register: normalised fraction with its rounding bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3Valid   <= 1'b0;
            s3Sign    <= 1'b0;
            s3Invalid <= 1'b0;
            s3Kind    <= KIND_NORMAL;
            s3Exp     <= '0;
            s3Frac    <= '0;
            s3Guard   <= 1'b0;
            s3Round   <= 1'b0;
            s3Sticky  <= 1'b0;
            s3Ctrl    <= '0;
        end else if (adv) begin
            s3Valid   <= s2Valid;
            s3Sign    <= s2Sign;
            s3Invalid <= s2Invalid;
            s3Kind    <= s2Kind;
            s3Exp     <= normExp;
            s3Frac    <= normFrac;
            s3Guard   <= normGuard;
            s3Round   <= normRound;
            s3Sticky  <= normSticky;
            s3Ctrl    <= s2Ctrl;
        end
    end

    // Round, post-normalise on mantissa carry, then resolve specials, overflow and underflow.
    always_comb begin
        anyLost = s3Guard | s3Round | s3Sticky;
        case (s3Ctrl)
            2'b00:   roundUp = s3Guard & (s3Round | s3Sticky | s3Frac[0]);
            2'b01:   roundUp = 1'b0;
            2'b10:   roundUp = !s3Sign & anyLost;
            default: roundUp = s3Sign & anyLost;
        endcase
        {carry, roundFrac} = {1'b0, s3Frac} + (MAN_W + 1)'(roundUp);
        roundExp = carry ? s3Exp + EXP_INC : s3Exp;
        toInf    = (s3Ctrl == 2'b00) || ((s3Ctrl == 2'b10) && !s3Sign) || ((s3Ctrl == 2'b11) && s3Sign);

        resultNext = '0;
        flagsNext  = '0;
        case (s3Kind)
            KIND_NAN: begin
                resultNext   = {1'b0, EXP_ONES, 1'b1, {(MAN_W - 1){1'b0}}};
                flagsNext[4] = s3Invalid;
            end
            KIND_INF:  resultNext = {s3Sign, EXP_ONES, {MAN_W{1'b0}}};
            KIND_ZERO: resultNext = {s3Sign, {(W - 1){1'b0}}};
            default: begin
                if (roundExp >= EXP_TOP) begin
                    flagsNext  = 5'b00101;
                    resultNext = toInf ? {s3Sign, EXP_ONES, {MAN_W{1'b0}}}
                                       : {s3Sign, EXP_MAXF, {MAN_W{1'b1}}};
                end else if (roundExp <= EXP_ZERO) begin
                    flagsNext  = 5'b00011;
                    resultNext = {s3Sign, {(W - 1){1'b0}}};
                end else begin
                    flagsNext  = {4'b0000, anyLost};
                    resultNext = {s3Sign, roundExp[EXP_W-1:0], roundFrac};
                end
            end
        endcase
    end

    // Output register: holds the result steady while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            P         <= '0;
            Flags     <= '0;
        end else if (adv) begin
            out_valid <= s3Valid;
            P         <= resultNext;
            Flags     <= flagsNext;
        end
    end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: exercises a single-precision and a double-precision fp_mult_pipe
// against an exact-integer reference model with a scoreboard queue.
module tb_fp_mult_pipe;

    typedef struct packed {
        logic [31:0] p;
        logic [4:0]  f;
    } ResultT;

    logic        clk = 1'b0;
    logic        rstN;
    logic        inValid, inReady, outValid, outReady;
    logic [31:0] a, b, p;
    logic [1:0]  ctrl;
    logic [4:0]  flags;

    logic        dInValid, dInReady, dOutValid, dOutReady;
    logic [63:0] dA, dB, dP;
    logic [1:0]  dCtrl;
    logic [4:0]  dFlags;

    int     checks = 0;
    int     failures = 0;
    ResultT expQ[$];

    always #5 clk = ~clk;

    fp_mult_pipe dut (
        .clk(clk), .rst_n(rstN),
        .in_valid(inValid), .in_ready(inReady),
        .A(a), .B(b), .Ctrl(ctrl),
        .out_valid(outValid), .out_ready(outReady),
        .P(p), .Flags(flags)
    );

    fp_mult_pipe #(.EXP_W(11), .MAN_W(52)) dutDouble (
        .clk(clk), .rst_n(rstN),
        .in_valid(dInValid), .in_ready(dInReady),
        .A(dA), .B(dB), .Ctrl(dCtrl),
        .out_valid(dOutValid), .out_ready(dOutReady),
        .P(dP), .Flags(dFlags)
    );

    // Reference product: exact integer mantissa product, rounded by comparing the
    // discarded remainder against one half.
    function automatic void refMul(input logic [63:0] opA, input logic [63:0] opB,
                                   input logic [1:0] mode, input int ew, input int mw,
                                   output logic [63:0] prod, output logic [4:0] fl);
        int           bias, expMax, ea, eb, e, shift;
        logic         sign, zA, zB, iA, iB, nA, nB, sgA, sgB, up, toInf;
        logic [63:0]  fa, fb, fracMask, signBit, infBits;
        logic [127:0] mant, q, rem, half;
        bias     = (1 << (ew - 1)) - 1;
        expMax   = (1 << ew) - 1;
        fracMask = (64'd1 << mw) - 64'd1;
        sign     = opA[ew + mw] ^ opB[ew + mw];
        ea       = int'((opA >> mw) & 64'(expMax));
        eb       = int'((opB >> mw) & 64'(expMax));
        fa       = opA & fracMask;
        fb       = opB & fracMask;
        zA  = (ea == 0);
        zB  = (eb == 0);
        iA  = (ea == expMax) && (fa == 0);
        iB  = (eb == expMax) && (fb == 0);
        nA  = (ea == expMax) && (fa != 0);
        nB  = (eb == expMax) && (fb != 0);
        sgA = nA && !fa[mw - 1];
        sgB = nB && !fb[mw - 1];
        signBit = 64'(sign) << (ew + mw);
        infBits = signBit | (64'(expMax) << mw);
        prod = '0;
        fl   = '0;
        if (nA || nB || (iA && zB) || (zA && iB)) begin
            prod  = (64'(expMax) << mw) | (64'd1 << (mw - 1));
            fl[4] = sgA || sgB || (iA && zB) || (zA && iB);
        end else if (iA || iB) begin
            prod = infBits;
        end else if (zA || zB) begin
            prod = signBit;
        end else begin
            mant  = (128'(fa) | (128'd1 << mw)) * (128'(fb) | (128'd1 << mw));
            shift = (mant >= (128'd1 << (2 * mw + 1))) ? mw + 1 : mw;
            q     = mant >> shift;
            rem   = mant & ((128'd1 << shift) - 128'd1);
            half  = 128'd1 << (shift - 1);
            up    = 1'b0;
            case (mode)
                2'b00: up = (rem > half) || ((rem == half) && q[0]);
                2'b01: up = 1'b0;
                2'b10: up = (rem != 0) && !sign;
                2'b11: up = (rem != 0) && sign;
            endcase
            if (up) q = q + 128'd1;
            e = ea + eb - bias + shift - mw;
            if (q == (128'd1 << (mw + 1))) begin
                q = q >> 1;
                e = e + 1;
            end
            if (e >= expMax) begin
                toInf = (mode == 2'b00) || ((mode == 2'b10) && !sign) || ((mode == 2'b11) && sign);
                prod  = toInf ? infBits : (signBit | (64'(expMax - 1) << mw) | fracMask);
                fl    = 5'b00101;
            end else if (e <= 0) begin
                prod = signBit;
                fl   = 5'b00011;
            end else begin
                prod = signBit | (64'(e) << mw) | (64'(q) & fracMask);
                fl   = {4'b0000, rem != 0};
            end
        end
    endfunction

    // Random single-precision operand biased towards specials and range edges.
    function automatic logic [31:0] randOperand();
        logic [7:0]  e;
        logic [22:0] f;
        f = 23'($urandom);
        case ($urandom_range(0, 9))
            0: e = 8'd0;
            1: begin e = 8'hFF; f = 23'd0; end
            2: begin e = 8'hFF; if (f == 23'd0) f = 23'd1; end
            3: e = 8'($urandom_range(200, 254));
            4: e = 8'($urandom_range(1, 60));
            5: begin e = 8'($urandom_range(126, 128)); f = {20'hFFFFF, 3'($urandom)}; end
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {1'($urandom), e, f};
    endfunction

    task automatic checkValue(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic pinModel(input string name, input logic [63:0] opA, input logic [63:0] opB,
                            input logic [1:0] mode, input int ew, input int mw,
                            input logic [63:0] expP, input logic [4:0] expF);
        logic [63:0] mp;
        logic [4:0]  mf;
        refMul(opA, opB, mode, ew, mw, mp, mf);
        checkValue({name, " model P"}, mp, expP);
        checkValue({name, " model Flags"}, 64'(mf), 64'(expF));
    endtask

    task automatic applyStimulus(input logic [31:0] opA, input logic [31:0] opB, input logic [1:0] mode);
        @(posedge clk);
        #1;
        a        = opA;
        b        = opB;
        ctrl     = mode;
        inValid  = 1'b1;
        outReady = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] expP, input logic [4:0] expF,
                               output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!outValid && waited < 20);
        checkValue({name, " out_valid"}, 64'(outValid), 64'd1);
        checkValue({name, " P"}, 64'(p), 64'(expP));
        checkValue({name, " Flags"}, 64'(flags), 64'(expF));
    endtask

    task automatic runSingle(input string name, input logic [31:0] opA, input logic [31:0] opB,
                             input logic [1:0] mode, input logic [31:0] expP, input logic [4:0] expF,
                             output int waited);
        pinModel(name, 64'(opA), 64'(opB), mode, 8, 23, 64'(expP), expF);
        applyStimulus(opA, opB, mode);
        checkOutput(name, expP, expF, waited);
    endtask

    task automatic runDouble(input string name, input logic [63:0] opA, input logic [63:0] opB,
                             input logic [1:0] mode, input logic [63:0] expP, input logic [4:0] expF);
        int waited;
        pinModel(name, opA, opB, mode, 11, 52, expP, expF);
        @(posedge clk);
        #1;
        dA       = opA;
        dB       = opB;
        dCtrl    = mode;
        dInValid = 1'b1;
        @(posedge clk);
        #1;
        dInValid = 1'b0;
        waited   = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!dOutValid && waited < 20);
        checkValue({name, " out_valid"}, 64'(dOutValid), 64'd1);
        checkValue({name, " P"}, dP, expP);
        checkValue({name, " Flags"}, 64'(dFlags), 64'(expF));
    endtask

    // Scoreboard: record every accepted operand, check every valid output against
    // the oldest outstanding expectation, and check outputs hold during a stall.
    initial begin
        ResultT      want;
        logic [63:0] mp;
        logic [4:0]  mf;
        logic        held;
        logic [31:0] heldP;
        logic [4:0]  heldF;
        held  = 1'b0;
        heldP = '0;
        heldF = '0;
        forever begin
            @(negedge clk);
            if (!rstN) begin
                expQ.delete();
                held = 1'b0;
            end else begin
                if (held) begin
                    checks++;
                    if (!outValid || p !== heldP || flags !== heldF) begin
                        failures++;
                        $display("[TB] FAIL stall hold: got valid=%0b P=%h Flags=%h, required valid=1 P=%h Flags=%h",
                                 outValid, p, flags, heldP, heldF);
                    end
                end
                held  = outValid && !outReady;
                heldP = p;
                heldF = flags;
                if (outValid) begin
                    checks++;
                    if (expQ.size() == 0) begin
                        failures++;
                        $display("[TB] FAIL unexpected output: got P=%h Flags=%h, required no output", p, flags);
                    end else begin
                        want = expQ[0];
                        if (p !== want.p || flags !== want.f) begin
                            failures++;
                            $display("[TB] FAIL model compare: got P=%h Flags=%h, required P=%h Flags=%h",
                                     p, flags, want.p, want.f);
                        end
                        if (outReady) void'(expQ.pop_front());
                    end
                end
                if (inValid && inReady) begin
                    refMul(64'(a), 64'(b), ctrl, 8, 23, mp, mf);
                    expQ.push_back(ResultT'{p: mp[31:0], f: mf});
                end
            end
        end
    end

    // Last-resort guard so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, directed vectors, stall stream, random traffic, reset mid-flight.
    initial begin
        int   waited;
        int   idx;
        int   cyc;
        logic took;
        rstN      = 1'b0;
        inValid   = 1'b0;
        a         = '0;
        b         = '0;
        ctrl      = '0;
        outReady  = 1'b1;
        dInValid  = 1'b0;
        dA        = '0;
        dB        = '0;
        dCtrl     = '0;
        dOutReady = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;
        @(negedge clk);
        checkValue("reset out_valid", 64'(outValid), 64'd0);
        checkValue("reset P", 64'(p), 64'd0);
        checkValue("reset Flags", 64'(flags), 64'd0);
        checkValue("reset in_ready", 64'(inReady), 64'd1);

        runSingle("1.5x2", 32'h3FC00000, 32'h40000000, 2'b00, 32'h40400000, 5'h00, waited);
        checkValue("latency", 64'(waited), 64'd4);
        runSingle("rne ulp", 32'h3F800001, 32'h3F800001, 2'b00, 32'h3F800002, 5'h01, waited);
        runSingle("+inf ulp", 32'h3F800001, 32'h3F800001, 2'b10, 32'h3F800003, 5'h01, waited);
        runSingle("ovf rne", 32'h7F000000, 32'h7F000000, 2'b00, 32'h7F800000, 5'h05, waited);
        runSingle("ovf rtz", 32'h7F000000, 32'h7F000000, 2'b01, 32'h7F7FFFFF, 5'h05, waited);
        runSingle("inf*zero", 32'h7F800000, 32'h80000000, 2'b00, 32'h7FC00000, 5'h10, waited);
        runSingle("underflow", 32'h00800000, 32'h3F000000, 2'b00, 32'h00000000, 5'h03, waited);
        runSingle("qnan", 32'h7FC00001, 32'h3F800000, 2'b00, 32'h7FC00000, 5'h00, waited);
        runSingle("-inf ovf", 32'h7F000000, 32'hFF000000, 2'b10, 32'hFF7FFFFF, 5'h05, waited);

        // Back-to-back stream with downstream stalled during cycles 6..9.
        @(posedge clk);
        #1;
        idx     = 0;
        cyc     = 0;
        inValid = 1'b1;
        a       = randOperand();
        b       = randOperand();
        ctrl    = 2'($urandom);
        while (idx < 8 && cyc < 60) begin
            outReady = !(cyc >= 6 && cyc <= 9);
            @(negedge clk);
            took = inReady;
            if (cyc >= 6 && cyc <= 9) checkValue("stall in_ready", 64'(inReady), 64'd0);
            @(posedge clk);
            #1;
            cyc++;
            if (took) begin
                idx++;
                a    = randOperand();
                b    = randOperand();
                ctrl = 2'($urandom);
                if (idx >= 8) inValid = 1'b0;
            end
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        checkValue("stream accepted", 64'(idx), 64'd8);
        waited = 0;
        while (expQ.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkValue("stream drained", 64'(expQ.size()), 64'd0);

        // Random traffic on both handshakes.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            inValid  = ($urandom_range(0, 3) != 0);
            a        = randOperand();
            b        = randOperand();
            ctrl     = 2'($urandom);
            outReady = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1;
        inValid  = 1'b0;
        outReady = 1'b1;
        waited   = 0;
        while (expQ.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkValue("random drained", 64'(expQ.size()), 64'd0);

        runDouble("dp 1.5x2", 64'h3FF8000000000000, 64'h4000000000000000, 2'b00, 64'h4008000000000000, 5'h00);
        runDouble("dp +inf ulp", 64'h3FF0000000000001, 64'h3FF0000000000001, 2'b10, 64'h3FF0000000000003, 5'h01);

        // Three operands in flight, then reset: nothing may come out afterwards.
        @(posedge clk);
        #1;
        outReady = 1'b1;
        inValid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a    = 32'h3FC00000;
            b    = randOperand();
            ctrl = 2'($urandom);
            @(posedge clk);
            #1;
        end
        inValid = 1'b0;
        rstN    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        @(negedge clk);
        checkValue("post-reset P", 64'(p), 64'd0);
        checkValue("post-reset Flags", 64'(flags), 64'd0);
        for (int i = 0; i < 8; i++) begin
            checkValue("post-reset out_valid", 64'(outValid), 64'd0);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
